// File: rtl/pulse_req_arbiter.sv
// pulse_req_arbiter: round-robin share of one pulse generator between two dav_/rfd producers.
module pulse_req_arbiter #(
   parameter int FIRST_PRIO = 0,
   parameter int CNT_W      = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             dav0_,
   input  logic [1:0]       numero0,
   output logic             rfd0,
   input  logic             dav1_,
   input  logic [1:0]       numero1,
   output logic             rfd1,
   output logic [1:0]       numero,
   output logic             dav_,
   input  logic             rfd,
   output logic             grant,
   output logic [CNT_W-1:0] served0,
   output logic [CNT_W-1:0] served1
);
   typedef enum logic [1:0] {IDLE = 2'b00, OFFER = 2'b01, RELEASE = 2'b10} state_t;
   state_t           state_q;
   logic             rfd0_q, rfd1_q, dav_q, grant_q, prio_q;
   logic [1:0]       numero_q;
   logic [CNT_W-1:0] served0_q, served1_q;
   logic             pick_d, gdav_d;
   // both low -> priority holder; otherwise dav0_ high means only requester 1 is asking
   assign pick_d = (!dav0_ && !dav1_) ? prio_q : dav0_;
   assign gdav_d = grant_q ? dav1_ : dav0_;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rfd0_q    <= 1'b1;
         rfd1_q    <= 1'b1;
         dav_q     <= 1'b1;
         numero_q  <= '0;
         grant_q   <= 1'(FIRST_PRIO);
         prio_q    <= 1'(FIRST_PRIO);
         served0_q <= '0;
         served1_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (rfd && (!dav0_ || !dav1_)) begin
               numero_q <= pick_d ? numero1 : numero0;
               grant_q  <= pick_d;
               dav_q    <= 1'b0;
               rfd0_q   <= pick_d;
               rfd1_q   <= !pick_d;
               state_q  <= OFFER;
            end
            OFFER: if (!rfd) begin
               dav_q   <= 1'b1;
               state_q <= RELEASE;
            end
            RELEASE: if (gdav_d && rfd) begin
               if (!grant_q && served0_q != '1) served0_q <= served0_q + CNT_W'(1);
               if (grant_q && served1_q != '1) served1_q <= served1_q + CNT_W'(1);
               prio_q  <= !grant_q;
               rfd0_q  <= 1'b1;
               rfd1_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               dav_q   <= 1'b1;
               rfd0_q  <= 1'b1;
               rfd1_q  <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end
   assign rfd0    = rfd0_q;
   assign rfd1    = rfd1_q;
   assign dav_    = dav_q;
   assign numero  = numero_q;
   assign grant   = grant_q;
   assign served0 = served0_q;
   assign served1 = served1_q;
endmodule

// File: tb/tb_pulse_req_arbiter.sv
// tb_pulse_req_arbiter: two arbiters with pulse-generator models, random producers and a transaction-rule reference.
module tb_pulse_req_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       reset = 1'b0;
   logic       p_dav0_ = 1'b1, p_dav1_ = 1'b1, b_dav0_ = 1'b1;
   logic [1:0] p_num0 = 2'd0, p_num1 = 2'd0, b_num0 = 2'd0;
   logic       a_rfd0, a_rfd1, a_dav_, a_grant, b_rfd0, b_rfd1, b_dav_, b_grant;
   logic [1:0] a_num, b_num, b_s0, b_s1;
   logic [7:0] a_s0, a_s1;
   logic [1:0] g_rfd = 2'b11;
   int         g_cnt [2] = '{0, 0};
   int         n_chk = 0, n_fail = 0;
   int         glog [$];

   pulse_req_arbiter dut_a (
      .clock(clk), .reset(reset),
      .dav0_(p_dav0_), .numero0(p_num0), .rfd0(a_rfd0),
      .dav1_(p_dav1_), .numero1(p_num1), .rfd1(a_rfd1),
      .numero(a_num), .dav_(a_dav_), .rfd(g_rfd[0]),
      .grant(a_grant), .served0(a_s0), .served1(a_s1));

   pulse_req_arbiter #(.FIRST_PRIO(1), .CNT_W(2)) dut_b (
      .clock(clk), .reset(reset),
      .dav0_(b_dav0_), .numero0(b_num0), .rfd0(b_rfd0),
      .dav1_(1'b1), .numero1(2'b00), .rfd1(b_rfd1),
      .numero(b_num), .dav_(b_dav_), .rfd(g_rfd[1]),
      .grant(b_grant), .served0(b_s0), .served1(b_s1));

   // generators: accept on dav_ low while ready, then keep rfd low for 2*(numero+1) clocks
   always @(posedge clk)
      for (int g = 0; g < 2; g++)
         if (g_cnt[g] > 0) begin
            g_cnt[g] <= g_cnt[g] - 1;
            if (g_cnt[g] == 1) g_rfd[g] <= 1'b1;
         end else if (g_rfd[g] && !(g == 1 ? b_dav_ : a_dav_)) begin
            g_cnt[g] <= 2 * (int'(g == 1 ? b_num : a_num) + 1);
            g_rfd[g] <= 1'b0;
         end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // reference: one outstanding transaction at a time, described by owner and offer phase
   int m_own = -1, m_prio = 0, m_grant = 0, m_code = 0;
   bit m_off = 1'b0, m_d0, m_d1, m_r;
   int m_s [2] = '{0, 0};
   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_own = -1; m_off = 1'b0; m_prio = 0; m_grant = 0; m_code = 0; m_s = '{0, 0};
      end else begin
         m_d0 = p_dav0_; m_d1 = p_dav1_; m_r = g_rfd[0];
         if (m_own < 0) begin
            if (m_r && (!m_d0 || !m_d1)) begin
               m_own   = (!m_d0 && !m_d1) ? m_prio : (m_d0 ? 1 : 0);
               m_code  = (m_own == 1) ? int'(p_num1) : int'(p_num0);
               m_grant = m_own;
               m_off   = 1'b1;
            end
         end else if (m_off) begin
            if (!m_r) m_off = 1'b0;
         end else if ((m_own == 1 ? m_d1 : m_d0) && m_r) begin
            m_s[m_own] = (m_s[m_own] == 255) ? 255 : m_s[m_own] + 1;
            m_prio = 1 - m_own;
            m_own = -1;
         end
      end
      #1;
      chk("dav_", a_dav_, (m_own >= 0 && m_off) ? 0 : 1);
      chk("rfd0", a_rfd0, (m_own == 0) ? 0 : 1);
      chk("rfd1", a_rfd1, (m_own == 1) ? 0 : 1);
      chk("grant", a_grant, m_grant);
      chk("numero", a_num, m_code);
      chk("served0", a_s0, m_s[0]);
      chk("served1", a_s1, m_s[1]);
   end

   always @(negedge a_dav_) begin
      #1 glog.push_back(int'(a_grant));
   end

   function automatic logic rfdk(input int k);
      return k == 0 ? a_rfd0 : (k == 1 ? a_rfd1 : b_rfd0);
   endfunction

   task automatic drive(input int k, input logic v, input logic [1:0] c);
      if (k == 0) begin p_dav0_ = v; p_num0 = c; end
      else if (k == 1) begin p_dav1_ = v; p_num1 = c; end
      else begin b_dav0_ = v; b_num0 = c; end
   endtask

   task automatic req(input int k, input logic [1:0] code, input int hold);
      int t;
      @(negedge clk);
      drive(k, 1'b0, code);
      t = 0;
      while (rfdk(k) && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) chk("grant_timeout", 1, 0);
      repeat (hold) @(negedge clk);
      drive(k, 1'b1, 2'($urandom));
      t = 0;
      while (!rfdk(k) && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) chk("done_timeout", 1, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int t;
      #2 reset = 1'b1;
      @(negedge clk);
      chk("t1_b_grant", b_grant, 1);
      chk("t1_b_served0", b_s0, 0);
      reset = 1'b0;
      req(0, 2'b01, 0);
      chk("t2_served0", a_s0, 1);
      pulse_reset();
      glog.delete();
      fork
         req(0, 2'b00, 0);
         req(1, 2'b11, 1);
      join
      chk("t3_count", glog.size(), 2);
      chk("t3_first", glog.size() > 0 ? glog[0] : 9, 0);
      chk("t3_second", glog.size() > 1 ? glog[1] : 9, 1);
      chk("t3_served0", a_s0, 1);
      chk("t3_served1", a_s1, 1);
      glog.delete();
      fork
         begin req(0, 2'b10, 0); req(0, 2'b01, 0); end
         req(1, 2'b10, 2);
      join
      chk("t4_count", glog.size(), 3);
      chk("t4_first", glog.size() > 0 ? glog[0] : 9, 0);
      chk("t4_second", glog.size() > 1 ? glog[1] : 9, 1);
      chk("t4_third", glog.size() > 2 ? glog[2] : 9, 0);
      fork
         req(0, 2'b11, 0);
         begin
            t = 0;
            @(negedge clk);
            while (!(a_rfd0 == 1'b0 && a_dav_ == 1'b1) && t < 200) begin @(negedge clk); t++; end
            if (t >= 200) chk("t5_release_timeout", 1, 0);
            #2 reset = 1'b1;
            #1;
            chk("t5_rfd0", a_rfd0, 1);
            chk("t5_dav_", a_dav_, 1);
            chk("t5_gen_busy", g_rfd[0], 0);
            @(negedge clk);
            reset = 1'b0;
         end
      join
      req(1, 2'b01, 0);
      chk("t5_served1", a_s1, 1);
      for (int i = 0; i < 40; i++)
         fork
            if ($urandom_range(0, 3) != 0) begin
               repeat ($urandom_range(0, 4)) @(negedge clk);
               req(0, 2'($urandom), $urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) != 0) begin
               repeat ($urandom_range(0, 4)) @(negedge clk);
               req(1, 2'($urandom), $urandom_range(0, 3));
            end
         join
      for (int i = 0; i < 5; i++) req(2, 2'($urandom), $urandom_range(0, 2));
      chk("t6_served0", b_s0, 3);
      chk("t6_served1", b_s1, 0);
      chk("t6_grant", b_grant, 0);
      chk("t6_rfd1", b_rfd1, 1);
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
